// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg : shared op/state types and op-decode helpers for execute_muldiv
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package exec_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // MUL treats both operands as signed; its low half is sign-agnostic anyway.
  function automatic logic is_signed_rs1(input md_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_rs2(input md_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div(input md_op_e op);
    return op[2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_iter_core.sv
// ---------------------------------------------------------------------------
// md_iter_core : radix-2 shift-add multiply / restoring divide datapath
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module md_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic              o_done,
  output logic [2*XLEN-1:0] o_acc
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(XLEN - 1);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic              r_div;
  logic              r_run;
  logic [CW-1:0]     r_cnt;

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN-1:0]   w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [2*XLEN-1:0] w_div_nxt;

  // Multiply: acc = {partial product, multiplier}; divide: acc = {rem, quot}.
  // The shifted remainder needs XLEN+1 bits so the compare never loses its MSB.
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
  assign w_mul_nxt = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};
  assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge      = w_rem_sh >= {1'b0, r_b};
  assign w_diff    = w_rem_sh[XLEN-1:0] - r_b;
  assign w_div_nxt = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1} : {r_acc[2*XLEN-2:0], 1'b0};

  assign o_done = r_run && (r_cnt == C_LAST);
  assign o_acc  = r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_b   <= '0;
      r_div <= 1'b0;
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_acc <= {{XLEN{1'b0}}, i_a};
      r_b   <= i_b;
      r_div <= i_is_div;
      r_run <= 1'b1;
      r_cnt <= '0;
    end else if (r_run) begin
      if (i_abort) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_acc <= r_div ? w_div_nxt : w_mul_nxt;
        r_cnt <= r_cnt + CW'(1);
        if (o_done) r_run <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/execute_muldiv.sv
// ---------------------------------------------------------------------------
// execute_muldiv : multi-cycle RV32M/RV64M unit with valid/ready and flush
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module execute_muldiv
  import exec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op_spec,
  input  logic [XLEN-1:0] rs1_dat,
  input  logic [XLEN-1:0] rs2_dat,
  input  logic [4:0]      rd_ind,
  input  logic            flsh,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      rd_ind_out,
  output logic [XLEN-1:0] rd_dat_out,
  output logic            busy
);

  localparam logic [XLEN-1:0] C_ONE = XLEN'(1);
  localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       r_state;
  md_op_e          r_op;
  logic            r_neg;
  logic            r_div0;
  logic            r_ovf;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_dat;
  logic [4:0]      r_rd;
  logic            r_valid;

  md_op_e            w_op;
  logic              w_s1, w_s2, w_accept, w_early, w_core_done;
  logic              w_div0, w_ovf, w_neg;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_res, w_quot, w_rem;
  logic [2*XLEN-1:0] w_acc, w_prod;

  assign w_op     = md_op_e'(op_spec);
  assign w_s1     = is_signed_rs1(w_op) & rs1_dat[XLEN-1];
  assign w_s2     = is_signed_rs2(w_op) & rs2_dat[XLEN-1];
  assign w_mag1   = w_s1 ? (~rs1_dat + C_ONE) : rs1_dat;
  assign w_mag2   = w_s2 ? (~rs2_dat + C_ONE) : rs2_dat;
  assign w_neg    = (w_op == OP_REM) ? w_s1 : (w_s1 ^ w_s2);
  assign w_div0   = is_div(w_op) && (rs2_dat == '0);
  assign w_ovf    = ((w_op == OP_DIV) || (w_op == OP_REM)) && (rs1_dat == C_MIN) && (&rs2_dat);
  assign w_accept = (r_state == ST_IDLE) && in_valid && !flsh;
  // Special-case divides bail out on their first CALC cycle; NORM forces the value.
  assign w_early  = EARLY_OUT && (r_state == ST_CALC) && (r_div0 || r_ovf);

  md_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept),
    .i_abort  (flsh || w_early),
    .i_is_div (is_div(w_op)),
    .i_a      (w_mag1),
    .i_b      (w_mag2),
    .o_done   (w_core_done),
    .o_acc    (w_acc)
  );

  always_comb begin
    w_prod = r_neg ? (~w_acc + {{XLEN{1'b0}}, C_ONE}) : w_acc;
    w_quot = r_neg ? (~w_acc[XLEN-1:0] + C_ONE) : w_acc[XLEN-1:0];
    w_rem  = r_neg ? (~w_acc[2*XLEN-1:XLEN] + C_ONE) : w_acc[2*XLEN-1:XLEN];
    w_res  = w_prod[XLEN-1:0];
    case (r_op)
      OP_MUL:                       w_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_res = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_res = r_div0 ? '1 : (r_ovf ? C_MIN : w_quot);
      default:                      w_res = r_div0 ? r_rs1 : (r_ovf ? '0 : w_rem);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MUL;
      r_neg   <= 1'b0;
      r_div0  <= 1'b0;
      r_ovf   <= 1'b0;
      r_rs1   <= '0;
      r_dat   <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= w_op;
            r_neg   <= w_neg;
            r_div0  <= w_div0;
            r_ovf   <= w_ovf;
            r_rs1   <= rs1_dat;
            r_rd    <= rd_ind;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (flsh)                        r_state <= ST_IDLE;
          else if (w_early || w_core_done) r_state <= ST_NORM;
        end
        ST_NORM: begin
          if (flsh) begin
            r_state <= ST_IDLE;
          end else begin
            r_dat   <= w_res;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (flsh || out_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign out_valid  = r_valid;
  assign rd_ind_out = r_rd;
  assign rd_dat_out = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_execute_muldiv.sv
// ---------------------------------------------------------------------------
// tb_execute_muldiv : scoreboard bench, XLEN=32 (EARLY_OUT=1) and XLEN=64 (EARLY_OUT=0)
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_execute_muldiv;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid [2];
  logic [2:0]  op;
  logic [63:0] rs1, rs2;
  logic [4:0]  rd;
  logic        flsh, out_ready;
  logic        in_ready [2];
  logic        out_valid [2];
  logic        busy [2];
  logic [4:0]  rd_out [2];
  logic [31:0] dat32;
  logic [63:0] dat64;

  execute_muldiv #(.XLEN(32), .EARLY_OUT(1'b1)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .op_spec(op), .rs1_dat(rs1[31:0]), .rs2_dat(rs2[31:0]), .rd_ind(rd),
    .flsh(flsh), .out_valid(out_valid[0]), .out_ready(out_ready),
    .rd_ind_out(rd_out[0]), .rd_dat_out(dat32), .busy(busy[0])
  );

  execute_muldiv #(.XLEN(64), .EARLY_OUT(1'b0)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .op_spec(op), .rs1_dat(rs1), .rs2_dat(rs2), .rd_ind(rd),
    .flsh(flsh), .out_valid(out_valid[1]), .out_ready(out_ready),
    .rd_ind_out(rd_out[1]), .rd_dat_out(dat64), .busy(busy[1])
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic        held [2] = '{1'b0, 1'b0};
  logic [63:0] sv_dat [2];
  logic [4:0]  sv_rd [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ones_w(input int s);
    return (s == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] min_w(input int s);
    return (s == 1) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
  endfunction

  // Reference model: RISC-V M semantics on wide signed/unsigned integers.
  function automatic logic [63:0] ref_md(input int s, input logic [2:0] o,
                                         input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub, r;
    logic [63:0] am, bm, res;
    int w;
    w  = (s == 1) ? 64 : 32;
    am = a & ones_w(s);
    bm = b & ones_w(s);
    if (s == 1) begin
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
    end else begin
      sa = {{96{a[31]}}, a[31:0]};
      sb = {{96{b[31]}}, b[31:0]};
    end
    ua = {64'b0, am};
    ub = {64'b0, bm};
    case (o)
      3'd0: begin r = sa * sb; res = r[63:0]; end
      3'd1: begin r = sa * sb; r = r >>> w; res = r[63:0]; end
      3'd2: begin r = sa * ub; r = r >>> w; res = r[63:0]; end
      3'd3: begin r = ua * ub; r = r >> w;  res = r[63:0]; end
      3'd4: begin
        if (bm == 0) res = ones_w(s);
        else if (am == min_w(s) && bm == ones_w(s)) res = min_w(s);
        else begin r = sa / sb; res = r[63:0]; end
      end
      3'd5: begin
        if (bm == 0) res = ones_w(s);
        else begin r = ua / ub; res = r[63:0]; end
      end
      3'd6: begin
        if (bm == 0) res = am;
        else if (am == min_w(s) && bm == ones_w(s)) res = 64'd0;
        else begin r = sa % sb; res = r[63:0]; end
      end
      default: begin
        if (bm == 0) res = am;
        else begin r = ua % ub; res = r[63:0]; end
      end
    endcase
    return res & ones_w(s);
  endfunction

  function automatic int exp_lat(input int s, input logic [2:0] o,
                                 input logic [63:0] a, input logic [63:0] b);
    logic [63:0] am, bm;
    logic special;
    am = a & ones_w(s);
    bm = b & ones_w(s);
    special = o[2] && ((bm == 0) ||
              ((o == 3'd4 || o == 3'd6) && am == min_w(s) && bm == ones_w(s)));
    if (s == 0 && special) return 2;
    return ((s == 1) ? 64 : 32) + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic issue(input int s, input logic [2:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] r);
    exp_t e;
    int n = 0;
    while (!in_ready[s] && n < 200) begin step(); n++; end
    if (!in_ready[s]) begin
      chk("issue_wait_in_ready", {63'b0, in_ready[s]}, 64'd1);
      return;
    end
    op = o; rs1 = a; rs2 = b; rd = r;
    in_valid[s] = 1'b1;
    step();
    in_valid[s] = 1'b0;
    e.rd = r; e.data = ref_md(s, o, a, b); e.acc_cyc = cyc; e.lat = exp_lat(s, o, a, b);
    if (s == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic wait_idle(input int s);
    int n = 0;
    while ((busy[s] || ((s == 0) ? q0.size() : q1.size()) != 0) && n < 300) begin
      step(); n++;
    end
    chk("drain_busy", {63'b0, busy[s]}, 64'd0);
  endtask

  task automatic mon(input int s);
    exp_t e;
    logic [63:0] d;
    d = (s == 1) ? dat64 : {32'b0, dat32};
    if (rst) begin
      held[s] = 1'b0;
    end else if (out_valid[s]) begin
      if (!held[s]) begin
        if (((s == 0) ? q0.size() : q1.size()) == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: inst %0d data %h with no pending op", s, d);
        end else begin
          e = (s == 0) ? q0.pop_front() : q1.pop_front();
          chk("rd_dat_out", d, e.data);
          chk("rd_ind_out", {59'b0, rd_out[s]}, {59'b0, e.rd});
          chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
        end
        held[s] = 1'b1;
        sv_dat[s] = d;
        sv_rd[s] = rd_out[s];
      end else begin
        chk("hold_data", d, sv_dat[s]);
        chk("hold_rd", {59'b0, rd_out[s]}, {59'b0, sv_rd[s]});
        chk("in_ready_in_done", {63'b0, in_ready[s]}, 64'd0);
      end
      if (out_ready || flsh) held[s] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  function automatic logic [63:0] pick(input int s);
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = min_w(s);
      3: v = 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v & ones_w(s);
  endfunction

  logic [2:0]  d_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [63:0] d_a  [12] = '{64'd7, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFF9,
                             64'hFFFF_FFF9, 64'd100, 64'd100, 64'd5, 64'd5, 64'h8000_0000, 64'h8000_0000};
  logic [63:0] d_b  [12] = '{64'hFFFF_FFFD, 64'h8000_0000, 64'hFFFF_FFFF, 64'd2, 64'd2, 64'd2,
                             64'd7, 64'd7, 64'd0, 64'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF};

  initial begin
    rst = 1'b1; in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    op = '0; rs1 = '0; rs2 = '0; rd = '0; flsh = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    for (int s = 0; s < 2; s++) begin
      chk("rst_in_ready", {63'b0, in_ready[s]}, 64'd1);
      chk("rst_busy", {63'b0, busy[s]}, 64'd0);
      chk("rst_out_valid", {63'b0, out_valid[s]}, 64'd0);
    end
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      issue(0, d_op[i], d_a[i], d_b[i], 5'(i + 3));
      wait_idle(0);
      chk("in_ready_after", {63'b0, in_ready[0]}, 64'd1);
    end

    // Backpressure: result must be held in DONE.
    out_ready = 1'b0;
    issue(0, 3'd5, 64'd1000, 64'd9, 5'd17);
    for (int n = 0; n < 100 && !out_valid[0]; n++) step();
    repeat (10) step();
    chk("bp_out_valid", {63'b0, out_valid[0]}, 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", {63'b0, out_valid[0]}, 64'd0);
    chk("bp_release_in_ready", {63'b0, in_ready[0]}, 64'd1);

    // Flush in CALC drops the operation.
    issue(0, 3'd0, 64'd12345, 64'd678, 5'd9);
    repeat (5) step();
    flsh = 1'b1;
    step();
    flsh = 1'b0;
    void'(q0.pop_back());
    chk("flush_busy", {63'b0, busy[0]}, 64'd0);
    chk("flush_in_ready", {63'b0, in_ready[0]}, 64'd1);
    repeat (40) step();
    issue(0, 3'd1, 64'hDEAD_BEEF, 64'h1234_5678, 5'd11);
    wait_idle(0);

    // Reset mid-CALC.
    issue(0, 3'd4, 64'hFFFF_0000, 64'd3, 5'd21);
    repeat (10) step();
    rst = 1'b1;
    step();
    chk("rstmid_out_valid", {63'b0, out_valid[0]}, 64'd0);
    chk("rstmid_rd", {59'b0, rd_out[0]}, 64'd0);
    chk("rstmid_dat", {32'b0, dat32}, 64'd0);
    chk("rstmid_busy", {63'b0, busy[0]}, 64'd0);
    chk("rstmid_in_ready", {63'b0, in_ready[0]}, 64'd1);
    rst = 1'b0;
    void'(q0.pop_back());
    step();

    for (int i = 0; i < 40; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      issue(0, o, pick(0), pick(0), 5'($urandom_range(0, 31)));
      wait_idle(0);
    end

    issue(1, 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5);
    wait_idle(1);
    issue(1, 3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6);
    wait_idle(1);
    issue(1, 3'd4, 64'd5, 64'd0, 5'd7);
    wait_idle(1);
    for (int i = 0; i < 10; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      issue(1, o, pick(1), pick(1), 5'($urandom_range(0, 31)));
      wait_idle(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
